// File: rtl/dense_layer_ctrl.sv
// rtl/dense_layer_ctrl.sv - dense layer controller: index stream, weight-row accumulate, bias, shift, ReLU, output vector
// Optional feature macro: DENSE_LAYER_SATURATE_EN (clamp positive results to the OUT_WIDTH maximum instead of wrapping)
module dense_layer_ctrl #(
  parameter int NODES        = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int SHIFT        = 4,
  parameter int OUT_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          idx_valid,
  input  logic [ADDR_WIDTH-1:0]         idx_addr,
  input  logic                          idx_last,
  input  logic                          idx_null,
  output logic                          idx_ready,
  output logic [ADDR_WIDTH-1:0]         wt_addr,
  input  logic [NODES*WEIGHT_WIDTH-1:0] wt_data,
  input  logic                          bias_we,
  input  logic [NODES*WEIGHT_WIDTH-1:0] bias_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NODES*OUT_WIDTH-1:0]    out_data,
  output logic                          busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    RELU  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic                          pend_q, pend_d;
  logic [NODES*ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [NODES*WEIGHT_WIDTH-1:0] bias_q, bias_d;
  logic                          out_valid_q, out_valid_d;
  logic [NODES*OUT_WIDTH-1:0]    out_data_q, out_data_d;

  logic                          accept;
  logic [NODES*ACC_WIDTH-1:0]    acc_add;
  logic [NODES*OUT_WIDTH-1:0]    relu_vec;

  // Entries are only taken while collecting a frame; the weight memory sees the index directly.
  assign idx_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign accept    = idx_valid && idx_ready;
  assign wt_addr   = idx_addr;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

  // Per-lane datapath: weight accumulate and the bias + shift + ReLU result.
  always_comb begin
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic signed [ACC_WIDTH-1:0] b_ext;
    logic signed [ACC_WIDTH-1:0] acc_lane;
    logic signed [ACC_WIDTH-1:0] pre;
    logic signed [ACC_WIDTH-1:0] shifted;
    acc_add  = '0;
    relu_vec = '0;
    w_ext    = '0;
    b_ext    = '0;
    acc_lane = '0;
    pre      = '0;
    shifted  = '0;
    for (int n = 0; n < NODES; n++) begin
      w_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){wt_data[n*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}},
               wt_data[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
      b_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){bias_q[n*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}},
               bias_q[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
      acc_lane = acc_q[n*ACC_WIDTH +: ACC_WIDTH];
      // Both adds wrap modulo 2^ACC_WIDTH by construction of the width.
      acc_add[n*ACC_WIDTH +: ACC_WIDTH] = acc_lane + w_ext;
      pre     = acc_lane + b_ext;
      shifted = pre >>> SHIFT;
`ifdef DENSE_LAYER_SATURATE_EN
      if (shifted[ACC_WIDTH-1]) begin
        relu_vec[n*OUT_WIDTH +: OUT_WIDTH] = '0;
      end else if ((shifted >> OUT_WIDTH) != '0) begin
        relu_vec[n*OUT_WIDTH +: OUT_WIDTH] = '1;
      end else begin
        relu_vec[n*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(shifted);
      end
`else
      if (shifted[ACC_WIDTH-1]) begin
        relu_vec[n*OUT_WIDTH +: OUT_WIDTH] = '0;
      end else begin
        relu_vec[n*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(shifted);
      end
`endif
    end
  end

  // Next-state logic: frame sequencing, pending-row accumulate, bias load and output register.
  always_comb begin
    state_d     = state_q;
    pend_d      = accept && !idx_null;
    acc_d       = acc_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // Row data arrives one cycle after its accept, whatever idx_valid is doing now.
    if (pend_q) begin
      acc_d = acc_add;
    end

    // Biases may only change while no frame result is being computed.
    if (bias_we && ((state_q == IDLE) || (state_q == HOLD))) begin
      bias_d = bias_wdata;
    end

    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (accept) begin
          state_d = idx_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && idx_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RELU;
      end
      RELU: begin
        out_data_d  = relu_vec;
        out_valid_d = 1'b1;
        acc_d       = '0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// tb/tb_dense_layer_ctrl.sv - directed self-checking bench for dense_layer_ctrl
module tb_dense_layer_ctrl;

  localparam int NODES = 2;
  localparam int AW    = 10;
  localparam int WW    = 8;
  localparam int ACCW  = 20;
  localparam int OW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              idx_valid;
  logic [AW-1:0]     idx_addr;
  logic              idx_last;
  logic              idx_null;
  logic              bias_we;
  logic [NODES*WW-1:0] bias_wdata;
  logic              out_ready;
  logic [NODES*WW-1:0] wt_data;

  logic              idx_ready, idx_ready_s2;
  logic [AW-1:0]     wt_addr, wt_addr_s2;
  logic              out_valid, out_valid_s2;
  logic [NODES*OW-1:0] out_data, out_data_s2;
  logic              busy, busy_s2;

  logic [NODES*WW-1:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  dense_layer_ctrl #(
    .NODES(NODES), .ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(ACCW), .SHIFT(0), .OUT_WIDTH(OW)
  ) u_dut (
    .clk(clk), .reset(reset),
    .idx_valid(idx_valid), .idx_addr(idx_addr), .idx_last(idx_last),
    .idx_null(idx_null), .idx_ready(idx_ready),
    .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_we(bias_we), .bias_wdata(bias_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  dense_layer_ctrl #(
    .NODES(NODES), .ADDR_WIDTH(AW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(ACCW), .SHIFT(2), .OUT_WIDTH(OW)
  ) u_dut_s2 (
    .clk(clk), .reset(reset),
    .idx_valid(idx_valid), .idx_addr(idx_addr), .idx_last(idx_last),
    .idx_null(idx_null), .idx_ready(idx_ready_s2),
    .wt_addr(wt_addr_s2), .wt_data(wt_data),
    .bias_we(bias_we), .bias_wdata(bias_wdata),
    .out_valid(out_valid_s2), .out_ready(out_ready), .out_data(out_data_s2),
    .busy(busy_s2)
  );

  // Synchronous weight memory: row appears one cycle after its address.
  always @(posedge clk) wt_data <= mem[wt_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_entry(input logic [AW-1:0] a, input logic l, input logic n);
    idx_valid = 1'b1;
    idx_addr  = a;
    idx_last  = l;
    idx_null  = n;
    @(negedge clk);
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    idx_null  = 1'b0;
  endtask

  task automatic load_bias(input logic [NODES*WW-1:0] b);
    bias_we    = 1'b1;
    bias_wdata = b;
    @(negedge clk);
    bias_we    = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_frame(input string name, input logic [NODES*OW-1:0] exp,
                              input logic [NODES*OW-1:0] exp_s2);
    int c;
    wait_out(c);
    checks++;
    if (c !== 2) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, expected 2", name, c);
    end
    checks++;
    if (out_data !== exp) begin
      failures++;
      $display("FAIL %s out_data: got %h, expected %h", name, out_data, exp);
    end
    checks++;
    if (out_data_s2 !== exp_s2) begin
      failures++;
      $display("FAIL %s out_data_shift2: got %h, expected %h", name, out_data_s2, exp_s2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s handshake: got valid=%b busy=%b, expected 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (idx_ready !== 1'b1) begin failures++; $display("FAIL reset_idx_ready: got %b, expected 1", idx_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_basic();
    drive_entry(10'd5, 1'b0, 1'b0);
    drive_entry(10'd9, 1'b1, 1'b0);
    checks++;
    if (idx_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_drain: got ready=%b busy=%b, expected 0 1", idx_ready, busy);
    end
    finish_frame("basic", 16'h0007, 16'h0001);
  endtask

  task automatic test_null_bias();
    load_bias(16'hFB0A);
    drive_entry(10'd5, 1'b1, 1'b1);
    finish_frame("null_bias", 16'h000A, 16'h0002);
  endtask

  task automatic test_saturate();
    load_bias(16'h0000);
    drive_entry(10'd7, 1'b0, 1'b0);
    drive_entry(10'd7, 1'b0, 1'b0);
    drive_entry(10'd7, 1'b1, 1'b0);
`ifdef DENSE_LAYER_SATURATE_EN
    finish_frame("saturate", 16'hFFFF, 16'h4B4B);
`else
    finish_frame("wrap", 16'h2C2C, 16'h4B4B);
`endif
  endtask

  task automatic test_hold_stall();
    int c;
    drive_entry(10'd5, 1'b1, 1'b0);
    wait_out(c);
    checks++;
    if (c !== 2) begin failures++; $display("FAIL hold_latency: got %0d, expected 2", c); end
    idx_valid = 1'b1;
    idx_addr  = 10'd9;
    idx_last  = 1'b1;
    bias_we    = 1'b1;
    bias_wdata = 16'h0201;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bias_we = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0003 || idx_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got valid=%b data=%h ready=%b, expected 1 0003 0",
                 i, out_valid, out_data, idx_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release: got %b, expected 0", out_valid); end
    @(negedge clk);
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    finish_frame("held_entry_new_bias", 16'h0305, 16'h0001);
  endtask

  task automatic test_reset_mid();
    drive_entry(10'd5, 1'b0, 1'b0);
    drive_entry(10'd9, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || idx_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_state: got busy=%b ready=%b, expected 0 1", busy, idx_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_stale[%0d]: got %b, expected 0", i, out_valid); end
    end
    drive_entry(10'd5, 1'b1, 1'b0);
    finish_frame("after_reset", 16'h0003, 16'h0000);
  endtask

  task automatic test_bias_accum();
    load_bias(16'hFB0A);
    drive_entry(10'd9, 1'b0, 1'b0);
    bias_we    = 1'b1;
    bias_wdata = 16'h3232;
    drive_entry(10'd5, 1'b1, 1'b0);
    bias_we    = 1'b0;
    finish_frame("bias_in_accum", 16'h0011, 16'h0004);
  endtask

  initial begin
    reset      = 1'b1;
    idx_valid  = 1'b0;
    idx_addr   = '0;
    idx_last   = 1'b0;
    idx_null   = 1'b0;
    bias_we    = 1'b0;
    bias_wdata = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[5] = 16'hFE03;
    mem[9] = 16'h0104;
    mem[7] = 16'h6464;
    @(negedge clk);
    test_reset();
    test_basic();
    test_null_bias();
    test_saturate();
    test_hold_stall();
    test_reset_mid();
    test_bias_accum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dense_layer_ctrl.md
# dense_layer_ctrl

Parametrised successor to the first-layer controller of the neural-network pipeline. Consumes a stream of active-pixel indices for one frame and fetches each index's weight row from an external synchronous weight memory. Accumulates per-node signed sums, adds stored biases, applies shift + ReLU and presents one registered output vector per frame to the next layer through a valid/ready handshake. Node count, widths and scaling are parameters, so the same block serves any dense layer.

## Interface
- NODES, 16, number of output nodes (lanes)
- ADDR_WIDTH, 10, index / weight-row address width
- WEIGHT_WIDTH, 8, signed weight and bias width per lane
- ACC_WIDTH, 20, signed accumulator width per lane (≥ WEIGHT_WIDTH+1)
- SHIFT, 4, arithmetic right shift applied before ReLU (0..ACC_WIDTH-1)
- OUT_WIDTH, 8, unsigned output width per lane
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- idx_valid  in  1  index entry available
- idx_addr  in  ADDR_WIDTH  active-pixel index = weight-row address
- idx_last  in  1  entry is final of frame
- idx_null  in  1  entry carries no address (empty-frame terminator); no accumulation
- idx_ready  out  1  entry accepted when idx_valid && idx_ready
- wt_addr  out  ADDR_WIDTH  weight-memory read address (combinational = idx_addr)
- wt_data  in  NODES*WEIGHT_WIDTH  row data, valid one cycle after wt_addr; lane n at [n*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- bias_we  in  1  bias load strobe
- bias_wdata  in  NODES*WEIGHT_WIDTH  bias vector, same lane packing
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_data  out  NODES*OUT_WIDTH  registered result vector
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, RELU, HOLD.
- IDLE: idx_ready=1; acc cleared. First accepted entry → ACCUM (or DRAIN if idx_last).
- ACCUM: idx_ready=1; each accepted non-null entry sets a 1-cycle pending flag; next cycle every lane adds sign-extended wt_data lane to acc. Back-to-back accepts allowed (one row per cycle). Accept with idx_last → DRAIN.
- DRAIN: idx_ready=0; pending weight of last entry accumulated → RELU.
- RELU: out_data lane = f((acc + sext(bias)) >>> SHIFT); out_valid set; acc cleared → HOLD.
- HOLD: idx_ready=0; out_valid && out_ready → out_valid=0, → IDLE.
- f: negative → 0; else low OUT_WIDTH bits (see Configuration).
- Accumulation and bias add wrap modulo 2^ACC_WIDTH; no overflow flag.
- idx_null entries accepted but never set pending; null+last gives bias-only result. Null without last is consumed and ignored.
- bias_we honoured only in IDLE or HOLD; ignored otherwise. Bias used is value held in RELU cycle.
- Duplicate indices in a frame are accumulated twice.

## Timing
- Reset values: state IDLE, idx_ready=1, out_valid=0, out_data=0, busy=0, acc=0, biases=0, pending=0.
- Reset mid-frame or in HOLD: frame discarded, no out_valid pulse, pending weight dropped.
- Memory contract: wt_data sampled exactly one cycle after the accept cycle, regardless of idx_valid in that cycle.
- Latency: last entry accepted in cycle t → DRAIN t+1 → RELU t+2 → out_valid=1 from t+3.
- out_data stable while out_valid=1; out_valid held until handshake; out_ready ignored when out_valid=0.
- Frame throughput: K entries → K+3 cycles + output stall.
- idx_valid while idx_ready=0: entry stays upstream, not consumed.

## Configuration
- DENSE_LAYER_SATURATE_EN defined: positive shifted sums ≥ 2^OUT_WIDTH clamp to 2^OUT_WIDTH-1.
- Not defined: positive sums truncate to low OUT_WIDTH bits (wrap).

## Test plan
- NODES=2, SHIFT=0, biases {0,0}; weights row5={3,-2}, row9={4,1}; frame 5,9(last) → out_data {7,0}, out_valid at cycle t+3.
- Biases {10,-5}; single entry null+last → out_data {10,0}; no wt_data sampled.
- Row7={100,100}, SHIFT=0, OUT_WIDTH=8; 3× index 7 → 300: with SATURATE_EN {255,255}, without {44,44}.
- Hold out_ready=0 for 10 cycles → out_valid/out_data stable, idx_ready=0; bias_we in HOLD takes effect next frame only.
- reset asserted mid-ACCUM after 2 entries; new frame row5 only → result equals single-row result, no stale pulse.
- bias_we pulsed during ACCUM → ignored; result uses prior biases.
